// File: rtl/hog_pkg.sv
// Shared constants and types for the HOG cell-histogram datapath.
// Thresholds are tan(20/40/60/80 deg) in unsigned Q4.16.
package hog_pkg;

    localparam int unsigned NBINS = 9;

    localparam int unsigned T1 = 23853;
    localparam int unsigned T2 = 54992;
    localparam int unsigned T3 = 113512;
    localparam int unsigned T4 = 371674;

    typedef logic [3:0] bin_idx_t;

    typedef enum logic {
        EMPTY,
        FULL
    } out_state_t;

endpackage

// File: rtl/tan_bin_classify.sv
// Combinational map from a signed Q(TAN_I).(TAN_F) tangent to one of nine
// unsigned-orientation bins (20 degrees each over 0..180).
module tan_bin_classify
    import hog_pkg::*;
#(
    parameter int unsigned TAN_W = 20
) (
    input  logic [TAN_W-1:0] tan,
    output bin_idx_t         bin
);

    localparam logic [TAN_W:0] TH1 = (TAN_W+1)'(T1);
    localparam logic [TAN_W:0] TH2 = (TAN_W+1)'(T2);
    localparam logic [TAN_W:0] TH3 = (TAN_W+1)'(T3);
    localparam logic [TAN_W:0] TH4 = (TAN_W+1)'(T4);

    logic           neg;
    logic [TAN_W:0] mag;
    logic           ge1, ge2, ge3, ge4;

    always_comb begin
        neg = tan[TAN_W-1];
        // One extra bit so the most negative code negates without wrapping.
        mag = neg ? (~{1'b1, tan} + (TAN_W+1)'(1)) : {1'b0, tan};
        ge1 = (mag >= TH1);
        ge2 = (mag >= TH2);
        ge3 = (mag >= TH3);
        ge4 = (mag >= TH4);

        if (!neg) begin
            if      (ge4) bin = bin_idx_t'(4);
            else if (ge3) bin = bin_idx_t'(3);
            else if (ge2) bin = bin_idx_t'(2);
            else if (ge1) bin = bin_idx_t'(1);
            else          bin = bin_idx_t'(0);
        end else begin
            if      (ge4) bin = bin_idx_t'(4);
            else if (ge3) bin = bin_idx_t'(5);
            else if (ge2) bin = bin_idx_t'(6);
            else if (ge1) bin = bin_idx_t'(7);
            else          bin = bin_idx_t'(8);
        end
    end

endmodule

// File: rtl/cell_hist_acc.sv
// Accumulates gradient magnitudes into a 9-bin orientation histogram per
// CELL_N-sample cell and publishes each cell through a valid/ready register.
module cell_hist_acc
    import hog_pkg::*;
#(
    parameter  int unsigned MAG_W  = 13,
    parameter  int unsigned TAN_I  = 4,
    parameter  int unsigned TAN_F  = 16,
    parameter  int unsigned CELL_N = 64,
    localparam int unsigned BIN_W  = MAG_W + $clog2(CELL_N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [MAG_W-1:0]       magnitude,
    input  logic [TAN_I+TAN_F-1:0] tan,
    input  logic                   o_ready,
    output logic                   o_valid,
    output logic [NBINS*BIN_W-1:0] hist,
    output logic                   o_overflow
);

    localparam int unsigned TAN_W = TAN_I + TAN_F;
    localparam int unsigned CNT_W = $clog2(CELL_N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_N - 1);

    bin_idx_t cls_bin;

    tan_bin_classify #(
        .TAN_W(TAN_W)
    ) u_classify (
        .tan(tan),
        .bin(cls_bin)
    );

    // Stage 1: classified sample plus end-of-cell marker.
    logic [CNT_W-1:0] cnt;
    logic             s1_valid;
    logic             s1_last;
    bin_idx_t         s1_bin;
    logic [MAG_W-1:0] s1_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_bin   <= '0;
            s1_mag   <= '0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_bin  <= cls_bin;
                s1_mag  <= magnitude;
                s1_last <= (cnt == CNT_LAST);
                cnt     <= cnt + CNT_W'(1);
            end
        end
    end

    // Stage 2: accumulate; the closing sample snapshots into the bank and clears.
    logic [BIN_W-1:0] acc      [NBINS];
    logic [BIN_W-1:0] acc_next [NBINS];
    logic [BIN_W-1:0] bank     [NBINS];
    logic             cell_done;

    always_comb begin
        for (int unsigned k = 0; k < NBINS; k++) begin
            acc_next[k] = acc[k] + ((s1_bin == bin_idx_t'(k)) ? BIN_W'(s1_mag) : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_done <= 1'b0;
            for (int unsigned k = 0; k < NBINS; k++) begin
                acc[k]  <= '0;
                bank[k] <= '0;
            end
        end else begin
            cell_done <= s1_valid & s1_last;
            if (s1_valid) begin
                for (int unsigned k = 0; k < NBINS; k++) begin
                    if (s1_last) begin
                        bank[k] <= acc_next[k];
                        acc[k]  <= '0;
                    end else begin
                        acc[k]  <= acc_next[k];
                    end
                end
            end
        end
    end

    // Output register: hist only changes on load into EMPTY or on a transfer.
    out_state_t       state;
    logic [BIN_W-1:0] hist_r [NBINS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            for (int unsigned k = 0; k < NBINS; k++) begin
                hist_r[k] <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (cell_done) begin
                        for (int unsigned k = 0; k < NBINS; k++) begin
                            hist_r[k] <= bank[k];
                        end
                        state   <= FULL;
                        o_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (cell_done) begin
                        if (o_ready) begin
                            for (int unsigned k = 0; k < NBINS; k++) begin
                                hist_r[k] <= bank[k];
                            end
                        end else begin
                            o_overflow <= 1'b1;
                        end
                    end else if (o_ready) begin
                        state   <= EMPTY;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        hist = '0;
        for (int unsigned k = 0; k < NBINS; k++) begin
            hist[k*BIN_W +: BIN_W] = hist_r[k];
        end
    end

endmodule

// File: doc/cell_hist_acc.md
# cell_hist_acc

Downstream consumer of the gradient stage's `magnitude`/`tan`/`o_valid` stream. It maps each sample's signed tangent to one of 9 unsigned-orientation bins (20° each over 0–180°) and adds the sample's magnitude into that bin. After CELL_N accepted samples it publishes the 9-bin cell histogram through a valid/ready output register, then starts the next cell with cleared accumulators. The input side has no backpressure: every `i_valid` sample is consumed.

## Interface
- `MAG_W`, 13: magnitude width, unsigned Q9.4.
- `TAN_I`, 4: tangent integer bits, signed.
- `TAN_F`, 16: tangent fraction bits.
- `CELL_N`, 64: samples per cell; must be a power of 2.
- `BIN_W`, MAG_W + log2(CELL_N) (localparam, 19): width of one bin.
- `clk` in 1: clock; the block uses one clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_valid` in 1: sample strobe.
- `magnitude` in MAG_W: gradient magnitude.
- `tan` in TAN_I+TAN_F: signed Q4.16 value of ver/hor.
- `o_ready` in 1: consumer accepts the histogram.
- `o_valid` out 1: `hist` holds a complete cell.
- `hist` out 9*BIN_W: bin k occupies [k*BIN_W +: BIN_W]; bin 0 is in the LSBs.
- `o_overflow` out 1: sticky flag; a completed cell was dropped.

## Operation
- **Thresholds (Q4.16):**
  - T1 = 23853 (tan 20°)
  - T2 = 54992 (tan 40°)
  - T3 = 113512 (tan 60°)
  - T4 = 371674 (tan 80°)
- **Classification, t ≥ 0:** bin = count of Tn with t ≥ Tn, giving 0..4.
- **Classification, t < 0:** with a = −t:
  - a ≥ T4 → 4
  - a ≥ T3 → 5
  - a ≥ T2 → 6
  - a ≥ T1 → 7
  - otherwise → 8
- **Tangent edge values:**
  - t = 0 → bin 0.
  - The most negative code maps to bin 4.
- **Stage 1:** registers bin index, magnitude, valid, and `last`. `last` is set when the sample counter equals CELL_N−1.
- **Sample counter:** advances once per accepted sample and wraps to 0 after the last sample of a cell.
- **Stage 2, ordinary sample:** acc[bin] += magnitude, with no saturation. BIN_W guarantees there is no wrap.
- **Stage 2, last sample:**
  - The out bank is loaded with the accumulator contents, including this final addition.
  - All accumulators clear in the same edge.
- **Output FSM, EMPTY:** `o_valid` = 0. On cell completion, load the out bank and go to FULL.
- **Output FSM, FULL:** `o_valid` = 1 and `hist` is held stable.
  - `o_ready` = 1 with no completion → EMPTY.
  - Completion with `o_ready` = 1 in the same cycle → reload with the new cell and stay FULL. No overflow is flagged.
  - Completion with `o_ready` = 0 → the new cell is dropped, the old `hist` is kept, and `o_overflow` is set to 1.
- **Reset (any time, including mid-cell):**
  - Counter, pipeline valids, accumulators and out bank → 0.
  - FSM → EMPTY.
  - `o_valid` = 0, `o_overflow` = 0, `hist` = 0.
  - The first valid sample after reset is sample 0 of a new cell.

## Timing
- **Throughput:** one sample per clock; gaps in `i_valid` are allowed.
- **Latency:** the last sample sampled at edge k gives `o_valid` = 1 after edge k+2.
- **Back-to-back cells:** sample 0 of the next cell may arrive at edge k+1. It goes into the cleared accumulators and is not lost.
- **Handshake:** the output transfers on an edge where `o_valid` & `o_ready` are both 1. `hist` must not change while `o_valid` = 1 without a transfer.

## Structure
- **Package `hog_pkg`:**
  - NBINS = 9
  - Thresholds T1..T4
  - `bin_idx_t` (4-bit)
- **Sub-module `tan_bin_classify`:** combinational tan → bin_idx_t mapping. Stage-1 registers stay in the top level.

## Test plan
- **Single direction:** 64 samples, magnitude = 16, tan = 0 → bin0 = 1024, all other bins 0, `o_valid` high 2 cycles after the last sample.
- **Boundaries:** feed these tans, then pad with magnitude = 0 to finish the cell:
  - 23852 → bin 0; 23853 → 1; 54992 → 2; 113512 → 3
  - 371674 → 4; −371674 → 4; −371673 → 5
  - −23853 → 7; −1 → 8
  - Use magnitude = 1 except −371674, which uses magnitude = 2; this separates its contribution from +371674's within bin 4.
  - Expect each listed bin = 1, except bin 4 = 1 + 2 = 3.
- **Full-scale:** 64 samples, magnitude = 8191, tan = 113512 → bin3 = 524224 exactly.
- **Backpressure:**
  - Hold `o_ready` = 0 across two cells → `hist` keeps the first cell and `o_overflow` = 1.
  - Repeat with `o_ready` = 1 on the completion edge → the second cell is presented and `o_overflow` stays 0.
- **Reset mid-cell:** assert `rst` after 30 samples → outputs go to 0 immediately. The next 64 samples give a histogram containing only those samples.
- **Gapped input:** random `i_valid` gaps over 3 cells → histograms match the reference model, and each completes exactly 64 valid samples after the previous one.
